// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder streaming operands LSB first through one FullAdder_1bit cell.
// Defining SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output (ovf).
module FullAdder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic c_q, c_d, cout_q, cout_d, done_q, done_d;
    logic fa_s, fa_c, run, load, last;
    logic [WIDTH:0] res_sh;

    FullAdder_1bit u_fa (
        .a(sha_q[0]),
        .b(shb_q[0]),
        .cin(c_q),
        .sum(fa_s),
        .cout(fa_c)
    );

    // New sum bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
    assign res_sh = {fa_s, res_q};
    assign last   = cnt_q == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end

    always_comb begin
        run    = state_q == RUN;
        load   = !run && start;
        sha_d  = load ? a : run ? sha_q >> 1 : sha_q;
        shb_d  = load ? b : run ? shb_q >> 1 : shb_q;
        c_d    = load ? cin : run ? fa_c : c_q;
        cnt_d  = load ? '0 : run ? cnt_q + 1'b1 : cnt_q;
        res_d  = run ? res_sh[WIDTH:1] : res_q;
        done_d = run && last;
        sum_d  = done_d ? res_sh[WIDTH:1] : sum_q;
        cout_d = done_d ? fa_c : cout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sha_q  <= '0;
            shb_q  <= '0;
            res_q  <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sha_q  <= sha_d;
            shb_q  <= shb_d;
            res_q  <= res_d;
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            c_q    <= c_d;
            cout_q <= cout_d;
            done_q <= done_d;
        end
    end

    assign busy = state_q == RUN;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;
    // On the last bit c_q is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ovf_q <= 1'b0;
        else if (done_d) ovf_q <= c_q ^ fa_c;
    end
    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against an arithmetic reference model.
module tb_serial_adder;
    localparam int W = 8;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic ovf;
`endif
    int total = 0, bad = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition, signed overflow from signed range.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return s > 127 || s < -128;
    endfunction

    task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] e;
        e = ref_add(x, y, c);
        chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(x, y, c)));
`endif
    endtask

    // Waits for done after an accepted start; returns edges elapsed (W+3 on timeout).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < W + 3) begin
            tick();
            n++;
        end
    endtask

    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n;
        logic [W-1:0] prev;
        a = x; b = y; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~x; b = ~y; cin = ~c;
        chk({tag, "_busy"}, 32'(busy), 1);
        wait_done(n);
        chk({tag, "_lat"}, 32'(n), W);
        chk({tag, "_idle"}, 32'(busy), 0);
        check_result(tag, x, y, c);
        prev = sum;
        tick();
        chk({tag, "_pulse"}, 32'(done), 0);
        chk({tag, "_hold"}, 32'(sum), 32'(prev));
    endtask

    initial begin
        int n, cnt;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        #20 rst_n = 1'b1;
        tick();

        op("basic", 8'h5A, 8'h3C, 1'b0);
        op("carry1", 8'hFF, 8'h01, 1'b0);
        op("carry2", 8'hFF, 8'h00, 1'b1);
        op("sovf", 8'h80, 8'h80, 1'b0);

        // Start while busy is ignored and operand changes have no effect.
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; a = 8'h33; b = 8'hCC;
        n = 3;
        while (!done && n < W + 3) begin tick(); n++; end
        chk("busy_lat", 32'(n), W);
        check_result("busy", 8'h10, 8'h20, 1'b0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin tick(); cnt += int'(busy) + int'(done); end
        chk("busy_nolaunch", 32'(cnt), 0);

        // Back-to-back with start held high.
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        a = 8'h7F;
        wait_done(n);
        chk("b2b_lat1", 32'(n), W);
        check_result("b2b1", 8'h01, 8'h01, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) start = 1'b0;
        end while (!done && n < W + 4);
        chk("b2b_period", 32'(n), W + 1);
        check_result("b2b2", 8'h7F, 8'h01, 1'b0);
        tick();

        // Reset mid-operation.
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_sum", 32'(sum), 0);
        chk("mid_cout", 32'(cout), 0);
        tick();
        #3 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin tick(); cnt += int'(done) + int'(busy); end
        chk("mid_nodone", 32'(cnt), 0);
        op("fresh", 8'hC3, 8'h4E, 1'b1);

        for (int i = 0; i < 40; i++)
            op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
